// File: rtl/neurospider_pkg.sv
// Shared Q8.8 constants and controller state encoding for the neuron pipeline
// (parameter-fetch stage and MAC/accumulate stage).
package neurospider_pkg;

  localparam int DATA_W    = 16;
  localparam int FRAC_BITS = 8;

  localparam logic [DATA_W-1:0] Q_MAX = 16'h7FFF;
  localparam logic [DATA_W-1:0] Q_MIN = 16'h8000;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCUM  = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_ACCUM  = ST_ACCUM,
    S_FINISH = ST_FINISH
  } state_e;

endpackage

// File: rtl/neuron_mac_accum_q_saturate.sv
// Converts a Q.16 accumulator back to Q8.8: arithmetic shift (floor), clamp to
// the Q8.8 range, then optional ReLU. Purely combinational.
module q_saturate
  import neurospider_pkg::*;
#(
  parameter int ACC_W   = 48,
  parameter bit RELU_EN = 1'b1
) (
  input  logic signed [ACC_W-1:0]  i_acc,
  output logic signed [DATA_W-1:0] o_val
);

  localparam logic signed [ACC_W-1:0] LIM_MAX = {{(ACC_W-DATA_W){1'b0}}, Q_MAX};
  localparam logic signed [ACC_W-1:0] LIM_MIN = {{(ACC_W-DATA_W){1'b1}}, Q_MIN};

  logic signed [ACC_W-1:0] w_shift;

  assign w_shift = i_acc >>> FRAC_BITS;

  // Clamp to the representable range; ReLU wins over the negative clamp.
  always_comb begin
    o_val = w_shift[DATA_W-1:0];
    if (w_shift > LIM_MAX) begin
      o_val = Q_MAX;
    end else if (w_shift < LIM_MIN) begin
      o_val = Q_MIN;
    end
    if (RELU_EN && w_shift[ACC_W-1]) begin
      o_val = '0;
    end
  end

endmodule

// File: rtl/neuron_mac_accum.sv
// Neuron multiply-accumulate stage: consumes (value, weight) pairs from the
// fetch stage, accumulates onto the bias and writes one Q8.8 activation.
//
//  state    | meaning
//  ---------+--------------------------------------------------------------
//  S_IDLE   | waiting for startAccum; latches count, address and bias
//  S_ACCUM  | 2-stage MAC: register product, then add it to accumulator
//  S_FINISH | one cycle: saturate/ReLU, register result and write strobe
module neuron_mac_accum
  import neurospider_pkg::*;
#(
  parameter int ACC_W   = 48,
  parameter bit RELU_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              startAccum,
  input  logic [DATA_W-1:0] numAdds,
  input  logic [DATA_W-1:0] neuronIdx,
  input  logic [DATA_W-1:0] biasVal,
  input  logic [DATA_W-1:0] inVal,
  input  logic [DATA_W-1:0] inWeight,
  input  logic              inWE,
  output logic [DATA_W-1:0] resultAddr,
  output logic [DATA_W-1:0] resultVal,
  output logic              resultWE,
  output logic              accumDone,
  output logic              busy
);

  state_e                     r_state;
  state_e                     w_state_nxt;
  logic [DATA_W-1:0]          r_num;
  logic [DATA_W-1:0]          r_idx;
  logic [DATA_W-1:0]          r_cnt;
  logic signed [2*DATA_W-1:0] r_prod;
  logic                       r_prod_valid;
  logic signed [ACC_W-1:0]    r_acc;
  logic [DATA_W-1:0]          r_result_val;
  logic [DATA_W-1:0]          r_result_addr;
  logic                       r_result_we;
  logic                       w_last;
  logic                       w_take;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [DATA_W-1:0]   w_sat;

  // The product in flight is the final one: once it lands, no further pair
  // may enter the pipeline, so an extra strobe in that cycle is dropped.
  assign w_last = r_prod_valid && ((r_cnt + 1'b1) == r_num);
  assign w_take = (r_state == S_ACCUM) && inWE && !w_last;
  assign w_prod = $signed(inVal) * $signed(inWeight);

  q_saturate #(
    .ACC_W   (ACC_W),
    .RELU_EN (RELU_EN)
  ) u_sat (
    .i_acc (r_acc),
    .o_val (w_sat)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (startAccum) begin
          w_state_nxt = (numAdds == '0) ? S_FINISH : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (w_last) begin
          w_state_nxt = S_FINISH;
        end
      end
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: start latching, product/accumulate pipeline and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_num         <= '0;
      r_idx         <= '0;
      r_cnt         <= '0;
      r_prod        <= '0;
      r_prod_valid  <= 1'b0;
      r_acc         <= '0;
      r_result_val  <= '0;
      r_result_addr <= '0;
      r_result_we   <= 1'b0;
    end else begin
      r_result_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (startAccum) begin
            r_num        <= numAdds;
            r_idx        <= neuronIdx;
            r_acc        <= {{(ACC_W-DATA_W-FRAC_BITS){biasVal[DATA_W-1]}}, biasVal,
                             {FRAC_BITS{1'b0}}};
            r_cnt        <= '0;
            r_prod_valid <= 1'b0;
          end
        end
        S_ACCUM: begin
          r_prod_valid <= w_take;
          if (w_take) begin
            r_prod <= w_prod;
          end
          if (r_prod_valid) begin
            r_acc <= r_acc + {{(ACC_W-2*DATA_W){r_prod[2*DATA_W-1]}}, r_prod};
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_FINISH: begin
          r_result_val  <= w_sat;
          r_result_addr <= r_idx;
          r_result_we   <= 1'b1;
          r_prod_valid  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign resultVal  = r_result_val;
  assign resultAddr = r_result_addr;
  assign resultWE   = r_result_we;
  assign accumDone  = r_result_we;
  assign busy       = (r_state != S_IDLE);

endmodule
